// File: rtl/aud_core_pkg.sv
// Shared audio-core constants: default FIFO word width and pointer width.
// No logic, no latency.
// No flow control; consumers size their storage from these values.
package aud_core_pkg;

  // Default FIFO geometry: 32-bit words, 16 entries.
  localparam int AUD_FIFO_DW = 32;
  localparam int AUD_FIFO_AW = 4;

endpackage : aud_core_pkg

// File: rtl/sfifo_mem.sv
// Simple dual-port storage array for sfifo: one write port, one read port.
// Write lands on the rising clock edge; read data is combinational from raddr_i.
// No flow control; the caller gates we_i. Contents are never reset.
module sfifo_mem
  import aud_core_pkg::*;
#(
  parameter int DATA_WIDTH    = AUD_FIFO_DW,
  parameter int ADDRESS_WIDTH = AUD_FIFO_AW
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [ADDRESS_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdat_i,
  input  logic [ADDRESS_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdat_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDRESS_WIDTH];

  // Store the write word; no reset so the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdat_i;
    end
  end

  assign rdat_o = mem_q[raddr_i];

endmodule : sfifo_mem

// File: rtl/sfifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and level/error flags.
// Written word visible on dat_o one cycle after the write edge; no same-cycle bypass.
// Writes into a full FIFO are refused unless a read is accepted in the same cycle.
module sfifo
  import aud_core_pkg::*;
#(
  parameter int DATA_WIDTH    = AUD_FIFO_DW,
  parameter int ADDRESS_WIDTH = AUD_FIFO_AW,
  parameter int AFULL_LVL     = (2**ADDRESS_WIDTH) - 2,
  parameter int AEMPTY_LVL    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  input  logic                     we_i,
  input  logic                     re_i,
  output logic [DATA_WIDTH-1:0]    dat_o,
  output logic [ADDRESS_WIDTH:0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     afull_o,
  output logic                     aempty_o,
  output logic                     ovf_o,
  output logic                     udf_o
);

  localparam int CW = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(2**ADDRESS_WIDTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

  logic [ADDRESS_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDRESS_WIDTH-1:0] rptr_q, rptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic                     udf_q, udf_d;
  logic                     rd_ok, wr_ok, mem_we;

  // A read frees a slot this cycle, so a full FIFO can still take a write alongside it.
  assign rd_ok  = re_i && !empty_o;
  assign wr_ok  = we_i && (!full_o || rd_ok);
  // Flush and reset drop the write so memory only changes on a committed push.
  assign mem_we = wr_ok && !clr_i && !rst;

  sfifo_mem #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wptr_q),
    .wdat_i  (dat_i),
    .raddr_i (rptr_q),
    .rdat_o  (dat_o)
  );

  // Next-state for pointers, occupancy and sticky errors; flush wins over traffic.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (we_i && !wr_ok);
    udf_d   = udf_q | (re_i && !rd_ok);
    if (wr_ok) begin
      wptr_d = wptr_q + ADDRESS_WIDTH'(1);
    end
    if (rd_ok) begin
      rptr_d = rptr_q + ADDRESS_WIDTH'(1);
    end
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CW'(1);
    end
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Level flags decode straight from the registered count, so they track count_o exactly.
  assign count_o  = count_q;
  assign full_o   = (count_q == DEPTH_C);
  assign empty_o  = (count_q == '0);
  assign afull_o  = (count_q >= AFULL_C);
  assign aempty_o = (count_q <= AEMPTY_C);
  assign ovf_o    = ovf_q;
  assign udf_o    = udf_q;

endmodule : sfifo

// File: tb/tb_sfifo.sv
// Self-checking bench for sfifo at DATA_WIDTH=8, depth 4, AFULL 3, AEMPTY 1.
// Vectors carry expected count and sticky flags; a data queue tracks expected dat_o.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_sfifo;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;
  localparam int AEL   = 1;

  logic          clk = 1'b0;
  logic          rst, clr_i, we_i, re_i;
  logic [DW-1:0] dat_i;
  logic [DW-1:0] dat_o;
  logic [AW:0]   count_o;
  logic          full_o, empty_o, afull_o, aempty_o, ovf_o, udf_o;

  sfifo #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .AFULL_LVL     (AFL),
    .AEMPTY_LVL    (AEL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr_i),
    .dat_i    (dat_i),
    .we_i     (we_i),
    .re_i     (re_i),
    .dat_o    (dat_o),
    .count_o  (count_o),
    .full_o   (full_o),
    .empty_o  (empty_o),
    .afull_o  (afull_o),
    .aempty_o (aempty_o),
    .ovf_o    (ovf_o),
    .udf_o    (udf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we, re, clr, rs;
    logic [DW-1:0] din;
    int            cnt;
    logic          ovf, udf;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] sb[$];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic re, input logic clr, input logic rs,
                     input logic [DW-1:0] din, input int cnt, input logic ovf, input logic udf);
    vec_t v;
    v.we = we; v.re = re; v.clr = clr; v.rs = rs; v.din = din;
    v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endtask

  // One clock of stimulus with the scoreboard updated from the bench's own acceptance rules.
  task automatic run_vec(input vec_t v, input int idx);
    bit m_rd, m_wr;
    @(negedge clk);
    we_i = v.we; re_i = v.re; clr_i = v.clr; rst = v.rs; dat_i = v.din;
    m_rd = v.re && (sb.size() > 0);
    m_wr = v.we && ((sb.size() < DEPTH) || m_rd);
    #1;
    if (v.rs || v.clr) begin
      sb.delete();
    end else begin
      if (m_rd) begin
        chk($sformatf("v%0d_read_dat", idx), int'(dat_o), int'(sb[0]));
        void'(sb.pop_front());
      end
      if (m_wr) sb.push_back(v.din);
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_count", idx),  int'(count_o),  v.cnt);
    chk($sformatf("v%0d_full", idx),   int'(full_o),   int'(v.cnt == DEPTH));
    chk($sformatf("v%0d_empty", idx),  int'(empty_o),  int'(v.cnt == 0));
    chk($sformatf("v%0d_afull", idx),  int'(afull_o),  int'(v.cnt >= AFL));
    chk($sformatf("v%0d_aempty", idx), int'(aempty_o), int'(v.cnt <= AEL));
    chk($sformatf("v%0d_ovf", idx),    int'(ovf_o),    int'(v.ovf));
    chk($sformatf("v%0d_udf", idx),    int'(udf_o),    int'(v.udf));
    if (sb.size() > 0) chk($sformatf("v%0d_head", idx), int'(dat_o), int'(sb[0]));
  endtask

  initial begin
    rst = 1'b1; clr_i = 1'b0; we_i = 1'b0; re_i = 1'b0; dat_i = '0;

    // reset, then fill with 11..44
    add(0,0,0,1,8'h00, 0,0,0);
    add(1,0,0,0,8'h11, 1,0,0);
    add(1,0,0,0,8'h22, 2,0,0);
    add(1,0,0,0,8'h33, 3,0,0);
    add(1,0,0,0,8'h44, 4,0,0);
    // overflow attempt, then drain in order
    add(1,0,0,0,8'h55, 4,1,0);
    add(0,1,0,0,8'h00, 3,1,0);
    add(0,1,0,0,8'h00, 2,1,0);
    add(0,1,0,0,8'h00, 1,1,0);
    add(0,1,0,0,8'h00, 0,1,0);
    // flush clears sticky flags; refill and push-through on full
    add(0,0,1,0,8'h00, 0,0,0);
    add(1,0,0,0,8'h11, 1,0,0);
    add(1,0,0,0,8'h22, 2,0,0);
    add(1,0,0,0,8'h33, 3,0,0);
    add(1,0,0,0,8'h44, 4,0,0);
    add(1,1,0,0,8'h66, 4,0,0);
    add(0,1,0,0,8'h00, 3,0,0);
    add(0,1,0,0,8'h00, 2,0,0);
    add(0,1,0,0,8'h00, 1,0,0);
    add(0,1,0,0,8'h00, 0,0,0);
    // write+read on empty: write taken, read refused
    add(1,1,0,0,8'h77, 1,0,1);
    add(0,1,0,0,8'h00, 0,0,1);
    add(0,0,0,1,8'h00, 0,0,0);
    // interleaved traffic across the pointer wrap
    add(1,0,0,0,8'hA0, 1,0,0);
    add(1,0,0,0,8'hA1, 2,0,0);
    add(1,0,0,0,8'hA2, 3,0,0);
    add(0,1,0,0,8'h00, 2,0,0);
    add(1,0,0,0,8'hA3, 3,0,0);
    add(0,1,0,0,8'h00, 2,0,0);
    add(1,0,0,0,8'hA4, 3,0,0);
    add(1,1,0,0,8'hA5, 3,0,0);
    add(0,1,0,0,8'h00, 2,0,0);
    add(0,1,0,0,8'h00, 1,0,0);
    add(0,1,0,0,8'h00, 0,0,0);
    // count 3 with ovf set, then clr with a write
    add(1,0,0,0,8'hB0, 1,0,0);
    add(1,0,0,0,8'hB1, 2,0,0);
    add(1,0,0,0,8'hB2, 3,0,0);
    add(1,0,0,0,8'hB3, 4,0,0);
    add(1,0,0,0,8'hB4, 4,1,0);
    add(0,1,0,0,8'h00, 3,1,0);
    add(1,0,1,0,8'h99, 0,0,0);
    // same again, ended by rst with a write
    add(1,0,0,0,8'hC0, 1,0,0);
    add(1,0,0,0,8'hC1, 2,0,0);
    add(1,0,0,0,8'hC2, 3,0,0);
    add(1,0,0,0,8'hC3, 4,0,0);
    add(1,0,0,0,8'hC4, 4,1,0);
    add(0,1,0,0,8'h00, 3,1,0);
    add(1,0,0,1,8'h99, 0,0,0);
    // read on empty sets udf only
    add(0,1,0,0,8'h00, 0,0,1);
    add(0,0,0,1,8'h00, 0,0,0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // No same-cycle bypass: before the write edge the FIFO still reads empty.
    @(negedge clk);
    rst = 1'b0; clr_i = 1'b0; re_i = 1'b0; we_i = 1'b1; dat_i = 8'hAB;
    #1;
    chk("nobypass_empty", int'(empty_o), 1);
    chk("nobypass_count", int'(count_o), 0);
    sb.push_back(8'hAB);
    @(posedge clk);
    #1;
    chk("fwft_dat", int'(dat_o), int'(8'hAB));
    chk("fwft_count", int'(count_o), 1);

    // Reset mid-stream discards stored words; next write becomes the new head.
    begin
      vec_t v;
      v.we = 1; v.re = 0; v.clr = 0; v.rs = 0; v.din = 8'hCD; v.cnt = 2; v.ovf = 0; v.udf = 0;
      run_vec(v, 900);
      v.we = 0; v.rs = 1; v.cnt = 0;
      run_vec(v, 901);
      v.we = 1; v.rs = 0; v.din = 8'hEF; v.cnt = 1;
      run_vec(v, 902);
    end
    chk("post_rst_head", int'(dat_o), int'(8'hEF));

    @(negedge clk);
    we_i = 1'b0; re_i = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sfifo

// File: doc/sfifo.md
SFIFO -- requirements
Module: sfifo

Interface
REQ-001 Parameter DATA_WIDTH, 32, word width in bits.
REQ-002 Parameter ADDRESS_WIDTH, 4, pointer width; FIFO_DEPTH = 2**ADDRESS_WIDTH words.
REQ-003 Parameter AFULL_LVL, FIFO_DEPTH-2, almost-full threshold (words).
REQ-004 Parameter AEMPTY_LVL, 2, almost-empty threshold (words).
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 clr_i  input  1  synchronous flush; same effect as rst on pointers, count and flags.
REQ-008 dat_i  input  DATA_WIDTH  write data.
REQ-009 we_i  input  1  write request, level-sampled per clk.
REQ-010 re_i  input  1  read request (acknowledge of current dat_o), level-sampled per clk.
REQ-011 dat_o  output  DATA_WIDTH  head word, first-word-fall-through.
REQ-012 count_o  output  ADDRESS_WIDTH+1  registered occupancy, 0..FIFO_DEPTH.
REQ-013 full_o, empty_o  output  1 each  count_o==FIFO_DEPTH / count_o==0.
REQ-014 afull_o, aempty_o  output  1 each  count_o>=AFULL_LVL / count_o<=AEMPTY_LVL.
REQ-015 ovf_o, udf_o  output  1 each  sticky overflow / underflow error flags.

Function
REQ-016 Read accepted (rd_ok) SHALL be re_i && !empty_o.
REQ-017 Write accepted (wr_ok) SHALL be we_i && (!full_o || rd_ok); write into full FIFO succeeds only with same-cycle accepted read.
REQ-018 wr_ok SHALL store dat_i at wptr and increment wptr; rd_ok SHALL increment rptr; pointers wrap modulo FIFO_DEPTH.
REQ-019 count_o SHALL +1 on wr_ok only, -1 on rd_ok only, hold on both or neither.
REQ-020 dat_o SHALL equal mem[rptr] combinationally; valid when !empty_o, undefined-but-stable otherwise.
REQ-021 Write to empty FIFO SHALL appear on dat_o the cycle after the write edge (1-cycle latency); no same-cycle bypass.
REQ-022 Simultaneous we_i and re_i on empty FIFO: write accepted, read rejected, udf_o set.
REQ-023 full_o, empty_o, afull_o, aempty_o SHALL be decoded from registered count_o (no extra latency vs count_o).
REQ-024 ovf_o SHALL set on we_i && !wr_ok; udf_o SHALL set on re_i && !rd_ok; both hold until rst or clr_i.
REQ-025 Rejected operations SHALL not modify memory, pointers or count.
REQ-026 clr_i SHALL take priority over we_i/re_i in the same cycle; memory contents not cleared.

Reset
REQ-027 On rst: rptr=0, wptr=0, count_o=0, empty_o=1, full_o=0, aempty_o=1, afull_o=0 (if AFULL_LVL>0), ovf_o=0, udf_o=0.
REQ-028 rst SHALL override clr_i, we_i, re_i; rst mid-stream discards all stored words.
REQ-029 Memory array SHALL not be reset; dat_o value after reset is don't-care while empty_o=1.

Structure
REQ-030 No typedefs required; default widths and depth SHALL live in shared package aud_core_pkg as AUD_FIFO_DW/AUD_FIFO_AW constants.
REQ-031 Storage SHALL be a sub-module sfifo_mem: simple dual-port array, synchronous write, asynchronous read.
REQ-032 Control (pointers, count, flags) SHALL reside in sfifo; no latches, no multi-edge always blocks.

Verification (DATA_WIDTH=8, ADDRESS_WIDTH=2, AFULL_LVL=3, AEMPTY_LVL=1)
REQ-033 Reset, then write 0x11,0x22,0x33,0x44 -> count_o 1..4, full_o=1 after 4th, afull_o=1 from count 3, dat_o=0x11 throughout.
REQ-034 Full FIFO, we_i=1 re_i=0 with 0x55 -> ovf_o=1, count_o stays 4, subsequent reads return 0x11,0x22,0x33,0x44 then empty_o=1.
REQ-035 Full FIFO, we_i=re_i=1 with 0x66 -> count_o stays 4, dat_o advances to 0x22, 0x66 read out 4th; no ovf_o.
REQ-036 Empty FIFO, we_i=re_i=1 with 0x77 -> count_o=1, udf_o=1, dat_o=0x77 next cycle.
REQ-037 Write 6/read 6 interleaved past pointer wrap -> data order preserved, count_o never exceeds 4.
REQ-038 Count 3 with ovf_o=1, assert clr_i with we_i=1 -> next cycle count_o=0, empty_o=1, ovf_o=0, write ignored; repeat with rst -> same.
